// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the MDU controller: op codes, FSM states, divider iteration count
// and the two's-complement negate helper used by the divide sign fix.
package mdu_ctrl_pkg;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;

  localparam int unsigned DIV_ITERS = 32;
  localparam logic [4:0]  DIV_LAST  = 5'(DIV_ITERS - 1);

  function automatic logic [31:0] neg_if(input logic n, input logic [31:0] v);
    return n ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_ctrl_div_iter.sv
// Restoring radix-2 divider datapath: one quotient bit per step on unsigned magnitudes.
// The step outputs expose the post-step values so the controller can capture the final bit.
module mdu_ctrl_div_iter
  import mdu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        step,
  input  logic        abort,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quot_step_o,
  output logic [31:0] rem_step_o
);

  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_dvs;
  logic [32:0] w_trial;
  logic [32:0] w_diff;
  logic        w_ge;

  // A zero divisor always "fits", so DIVU by zero yields all-ones quotient and rem = dividend.
  assign w_trial     = {r_rem, r_quo[31]};
  assign w_diff      = w_trial - {1'b0, r_dvs};
  assign w_ge        = (w_trial >= {1'b0, r_dvs});
  assign rem_step_o  = w_ge ? w_diff[31:0] : w_trial[31:0];
  assign quot_step_o = {r_quo[30:0], w_ge};

  always_ff @(posedge clk) begin
    if (!resetn || abort) begin
      r_rem <= '0;
      r_quo <= '0;
      r_dvs <= '0;
    end else if (start) begin
      r_rem <= '0;
      r_quo <= dividend;
      r_dvs <= divisor;
    end else if (step) begin
      r_rem <= rem_step_o;
      r_quo <= quot_step_o;
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// MIPS multiply/divide controller: FSM, multiplier, divide sign fix, HI/LO and stall logic.
// Optional MDU_DIV_ZERO_FAST_EN short-circuits divide-by-zero straight to DONE.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        stall_o,
  output logic        busy_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  mdu_state_e  r_state;
  mdu_state_e  w_state_next;
  logic [31:0] r_hi, r_lo, r_res_hi, r_res_lo;
  logic [31:0] r_op_a, r_op_b;
  logic        r_mul_signed, r_sign_a, r_sign_b;
  logic [4:0]  r_cnt;

  logic        w_is_mul, w_is_div, w_is_mt, w_div_signed;
  logic        w_issue_mul, w_issue_div, w_div_zero_fast;
  logic        w_div_step, w_div_abort, w_commit, w_mt_write;
  logic        w_sa, w_sb;
  logic [31:0] w_abs_a, w_abs_b, w_quot_step, w_rem_step;
  logic [63:0] w_prod;

  assign w_is_mul     = (op == MDU_MULT) || (op == MDU_MULTU);
  assign w_is_div     = (op == MDU_DIV) || (op == MDU_DIVU);
  assign w_is_mt      = (op == MDU_MTHI) || (op == MDU_MTLO);
  assign w_div_signed = (op == MDU_DIV);
  assign w_sa         = w_div_signed & src_a[31];
  assign w_sb         = w_div_signed & src_b[31];
  assign w_abs_a      = neg_if(w_sa, src_a);
  assign w_abs_b      = neg_if(w_sb, src_b);

  // Sign-extending then truncating to 64 bits gives the signed product for MULT.
  assign w_prod = {{32{r_mul_signed & r_op_a[31]}}, r_op_a} *
                  {{32{r_mul_signed & r_op_b[31]}}, r_op_b};

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next    = r_state;
    stall_o         = 1'b0;
    w_issue_mul     = 1'b0;
    w_issue_div     = 1'b0;
    w_div_zero_fast = 1'b0;
    w_div_step      = 1'b0;
    w_div_abort     = 1'b0;
    w_commit        = 1'b0;
    w_mt_write      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (op_valid && w_is_mul) begin
          stall_o      = 1'b1;
          w_issue_mul  = 1'b1;
          w_state_next = ST_MUL;
        end else if (op_valid && w_is_div) begin
          stall_o = 1'b1;
`ifdef MDU_DIV_ZERO_FAST_EN
          if (src_b == 32'd0) begin
            w_div_zero_fast = 1'b1;
            w_state_next    = ST_DONE;
          end else begin
            w_issue_div  = 1'b1;
            w_state_next = ST_DIV;
          end
`else
          w_issue_div  = 1'b1;
          w_state_next = ST_DIV;
`endif
        end else if (op_valid && w_is_mt) begin
          w_mt_write = 1'b1;
        end
      end
      ST_MUL: begin
        stall_o      = 1'b1;
        w_state_next = ST_DONE;
      end
      ST_DIV: begin
        stall_o    = 1'b1;
        w_div_step = 1'b1;
        if (r_cnt == DIV_LAST) w_state_next = ST_DONE;
      end
      default: begin
        w_commit     = 1'b1;
        w_state_next = ST_IDLE;
      end
    endcase
    // Flush wins over everything: cancel issue, iteration, commit and MTHI/MTLO.
    if (flush) begin
      stall_o         = 1'b0;
      w_state_next    = ST_IDLE;
      w_issue_mul     = 1'b0;
      w_issue_div     = 1'b0;
      w_div_zero_fast = 1'b0;
      w_div_step      = 1'b0;
      w_div_abort     = 1'b1;
      w_commit        = 1'b0;
      w_mt_write      = 1'b0;
    end
  end

  mdu_ctrl_div_iter u_div_iter (
    .clk         (clk),
    .resetn      (resetn),
    .start       (w_issue_div),
    .step        (w_div_step),
    .abort       (w_div_abort),
    .dividend    (w_abs_a),
    .divisor     (w_abs_b),
    .quot_step_o (w_quot_step),
    .rem_step_o  (w_rem_step)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_hi         <= '0;
      r_lo         <= '0;
      r_res_hi     <= '0;
      r_res_lo     <= '0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_mul_signed <= 1'b0;
      r_sign_a     <= 1'b0;
      r_sign_b     <= 1'b0;
      r_cnt        <= '0;
    end else begin
      if (w_issue_mul) begin
        r_op_a       <= src_a;
        r_op_b       <= src_b;
        r_mul_signed <= (op == MDU_MULT);
      end
      if (w_issue_div) begin
        r_sign_a <= w_sa;
        r_sign_b <= w_sb;
        r_cnt    <= '0;
      end
      if (w_div_zero_fast) begin
        r_res_hi <= src_a;
        r_res_lo <= 32'hFFFF_FFFF;
      end
      if (r_state == ST_MUL) begin
        r_res_hi <= w_prod[63:32];
        r_res_lo <= w_prod[31:0];
      end
      if (w_div_step) begin
        r_cnt <= r_cnt + 5'd1;
        if (r_cnt == DIV_LAST) begin
          r_res_lo <= neg_if(r_sign_a ^ r_sign_b, w_quot_step);
          r_res_hi <= neg_if(r_sign_a, w_rem_step);
        end
      end
      if (w_commit) begin
        r_hi <= r_res_hi;
        r_lo <= r_res_lo;
      end
      if (w_mt_write) begin
        if (op == MDU_MTHI) r_hi <= src_a;
        else                r_lo <= src_a;
      end
    end
  end

  assign busy_o = (r_state != ST_IDLE);
  assign hi_o   = r_hi;
  assign lo_o   = r_lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: stall lengths, HI/LO results, flush and reset cancellation.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        op_valid = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        flush = 1'b0;
  logic        stall_o, busy_o;
  logic [31:0] hi_o, lo_o;

  int total = 0;
  int bad = 0;
  int stalls;
  int exp_zero_stalls;

  mdu_ctrl dut (
    .clk      (clk),
    .resetn   (resetn),
    .op_valid (op_valid),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .flush    (flush),
    .stall_o  (stall_o),
    .busy_o   (busy_o),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op at a falling edge, count stalled cycles, return after the commit edge.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int n);
    @(negedge clk);
    op_valid = 1'b1; op = o; src_a = a; src_b = b;
    #1;
    n = 0;
    while (stall_o === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    op_valid = 1'b0; op = MDU_NONE;
    #1;
    $display("op=%0d a=%h b=%h stalls=%0d hi=%h lo=%h", o, a, b, n, hi_o, lo_o);
  endtask

  initial begin
`ifdef MDU_DIV_ZERO_FAST_EN
    exp_zero_stalls = 1;
`else
    exp_zero_stalls = 33;
`endif
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", 64'(stall_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_hilo", {hi_o, lo_o}, 64'd0);
    resetn = 1'b1;

    run_op(MDU_MULT, 32'hFFFF_FFFE, 32'd3, stalls);
    check("mult_stall", 64'(stalls), 64'd2);
    check("mult_hilo", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFA);

    run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, stalls);
    check("multu_stall", 64'(stalls), 64'd2);
    check("multu_hilo", {hi_o, lo_o}, 64'hFFFF_FFFE_0000_0001);

    run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, stalls);
    check("div_stall", 64'(stalls), 64'd33);
    check("div_hilo", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);

    run_op(MDU_DIV, 32'd7, 32'hFFFF_FFFE, stalls);
    check("div2_hilo", {hi_o, lo_o}, 64'h0000_0001_FFFF_FFFD);

    run_op(MDU_DIVU, 32'd100, 32'd0, stalls);
    check("divz_stall", 64'(stalls), 64'(exp_zero_stalls));
    check("divz_hilo", {hi_o, lo_o}, 64'h0000_0064_FFFF_FFFF);

    // Flush in DONE must drop the product.
    @(negedge clk);
    op_valid = 1'b1; op = MDU_MULT; src_a = 32'd5; src_b = 32'd6;
    repeat (2) @(negedge clk);
    flush = 1'b1;
    #1;
    check("fdone_busy", 64'(busy_o), 64'd1);
    check("fdone_stall", 64'(stall_o), 64'd0);
    @(negedge clk);
    flush = 1'b0; op_valid = 1'b0; op = MDU_NONE;
    #1;
    $display("mult flushed in DONE: busy=%b hi=%h lo=%h", busy_o, hi_o, lo_o);
    check("fdone_idle", 64'(busy_o), 64'd0);
    check("fdone_hilo", {hi_o, lo_o}, 64'h0000_0064_FFFF_FFFF);

    // Flush at DIV iteration 10.
    @(negedge clk);
    op_valid = 1'b1; op = MDU_DIVU; src_a = 32'd50; src_b = 32'd7;
    repeat (11) @(negedge clk);
    #1;
    check("fdiv_busy", 64'(busy_o), 64'd1);
    flush = 1'b1;
    #1;
    check("fdiv_stall_f", 64'(stall_o), 64'd0);
    @(negedge clk);
    flush = 1'b0; op_valid = 1'b0; op = MDU_NONE;
    #1;
    $display("divu flushed at iter 10: busy=%b stall=%b hi=%h lo=%h", busy_o, stall_o, hi_o, lo_o);
    check("fdiv_idle", 64'(busy_o), 64'd0);
    check("fdiv_stall", 64'(stall_o), 64'd0);
    check("fdiv_hilo", {hi_o, lo_o}, 64'h0000_0064_FFFF_FFFF);

    run_op(MDU_MTLO, 32'h0000_1234, 32'd0, stalls);
    check("mtlo_stall", 64'(stalls), 64'd0);
    check("mtlo_hilo", {hi_o, lo_o}, 64'h0000_0064_0000_1234);

    // MTHI in the same cycle as flush is suppressed.
    @(negedge clk);
    op_valid = 1'b1; op = MDU_MTHI; src_a = 32'hDEAD_BEEF; flush = 1'b1;
    #1;
    check("mthif_stall", 64'(stall_o), 64'd0);
    @(negedge clk);
    op_valid = 1'b0; op = MDU_NONE; flush = 1'b0;
    #1;
    $display("mthi with flush: hi=%h lo=%h", hi_o, lo_o);
    check("mthif_hi", 64'(hi_o), 64'h64);

    run_op(MDU_MTHI, 32'hDEAD_BEEF, 32'd0, stalls);
    check("mthi_stall", 64'(stalls), 64'd0);
    check("mthi_hilo", {hi_o, lo_o}, 64'hDEAD_BEEF_0000_1234);

    // Reset in the middle of a divide.
    @(negedge clk);
    op_valid = 1'b1; op = MDU_DIV; src_a = 32'd1000; src_b = 32'd3;
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1; op_valid = 1'b0; op = MDU_NONE;
    #1;
    $display("reset mid-div: busy=%b stall=%b hi=%h lo=%h", busy_o, stall_o, hi_o, lo_o);
    check("rdiv_busy", 64'(busy_o), 64'd0);
    check("rdiv_stall", 64'(stall_o), 64'd0);
    check("rdiv_hilo", {hi_o, lo_o}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide unit controller for the MIPS execute stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO operations, sequences a single-cycle multiplier and a 32-iteration radix-2 divider, and owns the architectural HI/LO registers. While a multi-cycle operation runs it stalls the pipeline, and on an exception flush it cancels the operation cleanly.

## Interface

Parameters:
- none; all widths are fixed by the ISA (32-bit operands, 64-bit HI:LO).

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `op_valid` in 1: execute stage holds an MDU operation; held stable while `stall_o`=1.
- `op` in 3: operation code from `defines.vh` (MDU_NONE, MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO).
- `src_a` in 32: rs value (dividend / multiplicand / MTHI/MTLO data).
- `src_b` in 32: rt value (divisor / multiplier).
- `flush` in 1: exception or ERET flush; cancels the operation in execute.
- `stall_o` out 1: freezes the execute stage and everything upstream of it.
- `busy_o` out 1: state is not IDLE.
- `hi_o` out 32: architectural HI, read by MFHI.
- `lo_o` out 32: architectural LO, read by MFLO.

## Operation

- States: IDLE, MUL, DIV, DONE.
- Reset (`resetn`=0 at an edge):
  - state=IDLE, HI=LO=0, counter=0, internal result registers=0.
  - `stall_o`=0, `busy_o`=0.
- IDLE:
  - With `op_valid` and MULT/MULTU: latch operands, go to MUL.
  - With `op_valid` and DIV/DIVU: latch |a| and |b| (raw for DIVU), latch sign flags, clear counter, go to DIV.
  - MTHI/MTLO: write HI or LO at the edge. No stall, no state change.
- MUL:
  - Compute the 64-bit product (signed for MULT) into res_hi:res_lo.
  - Go to DONE.
- DIV:
  - Restoring divide, one quotient bit per cycle, counter 0..31.
  - After counter==31, apply sign fix and go to DONE: quotient negated if sign_a^sign_b; remainder takes sign of a.
- DONE:
  - `stall_o`=0; the instruction leaves execute this cycle.
  - HI:LO ← res_hi:res_lo at the edge. `op_valid` is ignored here, so the op is not re-issued.
  - Next state is IDLE.
- `stall_o` is combinational:
  - 1 when (IDLE & `op_valid` & op∈{MULT,MULTU,DIV,DIVU}), or in state MUL, or in state DIV.
  - Forced to 0 when `flush`=1.
- Commit rule: HI/LO are written only at an edge where `stall_o`=0 and `flush`=0.
- Flush:
  - Any state goes to IDLE at the next edge; HI/LO are unchanged; the pending result is discarded.
  - A flush in IDLE blocks issue and blocks an MTHI/MTLO write.
  - A flush in DONE discards the result.
- Division by zero: behaviour is set by the configuration macro below.
- Simultaneous events: `flush` overrides every other action. `resetn`=0 overrides `flush`.

## Timing

- MULT/MULTU: `stall_o` high for 2 cycles (issue, MUL), then DONE. HI/LO are visible on the cycle after DONE.
- DIV/DIVU: `stall_o` high for 33 cycles (issue plus 32 DIV cycles), then DONE.
- MTHI/MTLO: 0 stall cycles. The new value appears on `hi_o`/`lo_o` the next cycle.
- MFHI directly after any MDU op reads the updated value; no forwarding is needed.
- `hi_o`/`lo_o` are driven straight from registers. `stall_o` has a combinational path from `op_valid`, `op` and `flush`.

## Configuration

- `MDU_DIV_ZERO_FAST_EN` defined:
  - A DIV/DIVU with `src_b`==0 goes IDLE→DONE directly (stall 1 cycle).
  - Result: HI=`src_a`, LO=32'hFFFFFFFF.
- Undefined:
  - Divide-by-zero runs the full 32 iterations.
  - For DIVU the result is HI=`src_a`, LO=32'hFFFFFFFF.
  - For DIV the result is architecturally unpredictable and is not checked.

## Structure

- `defines.vh` holds the MDU op codes, the state encodings and the iteration count (32).
- Sub-module `div_iter` holds the restoring divider datapath: partial remainder, quotient shift register, one-step subtract. Its controls are `start`, `step` and `abort` from `mdu_ctrl`.
- `mdu_ctrl` holds the FSM, counter, multiplier, sign fix, HI/LO registers and the stall logic.

## Test plan

- MULT a=0xFFFFFFFE (−2), b=3 → `stall_o` high for exactly 2 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- DIV a=−7, b=2 → `stall_o` high for 33 cycles; LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1).
- DIVU a=100, b=0, with and without `MDU_DIV_ZERO_FAST_EN` → HI=100, LO=0xFFFFFFFF. Stall is 1 cycle with the macro and 33 cycles without.
- DIVU started, `flush` asserted at DIV cycle 10 → IDLE next cycle, `stall_o`=0, HI/LO keep their prior values. A following MTLO 0x1234 then sets LO=0x1234.
- MTHI 0xDEADBEEF issued in the same cycle as `flush` → HI unchanged. Repeated without flush → HI=0xDEADBEEF the next cycle with no stall.
- `resetn` pulled low mid-DIV → the next cycle shows IDLE, HI=LO=0, `stall_o`=0.
